// File: rtl/chi_intr_scheduler.sv
// Interrupt message scheduler: round-robin over four level sources, one outstanding
// message at a time, with a programmable idle holdoff between accepted messages.
module chi_intr_scheduler #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [3:0]       src_pend,
  input  logic [3:0]       src_en,
  input  logic [CNT_W-1:0] holdoff_cycles,
  output logic             msi_req,
  output logic [1:0]       msi_vec,
  input  logic             msi_ack,
  output logic [3:0]       svc_mask,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, REQ, HOLDOFF} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       last_grant, last_grant_nxt;
  logic [1:0]       vec_nxt;
  logic             req_nxt;
  logic [3:0]       mask_nxt;
  logic [3:0]       eligible;

  // First eligible index above the previous grant, wrapping; k=4 wraps back to last.
  function automatic logic [1:0] rr_pick(input logic [3:0] elig, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && elig[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_comb begin
    eligible       = src_pend & src_en & ~svc_mask;
    state_nxt      = state;
    cnt_nxt        = cnt;
    last_grant_nxt = last_grant;
    req_nxt        = msi_req;
    vec_nxt        = msi_vec;
    // A source leaves the mask once its pending level has been seen low.
    mask_nxt       = svc_mask & src_pend;
    case (state)
      IDLE: begin
        if (|eligible) begin
          vec_nxt   = rr_pick(eligible, last_grant);
          req_nxt   = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (msi_ack) begin
          mask_nxt[msi_vec] = 1'b1;
          last_grant_nxt    = msi_vec;
          req_nxt           = 1'b0;
          if (holdoff_cycles == '0) begin
            state_nxt = IDLE;
          end else begin
            cnt_nxt   = holdoff_cycles;
            state_nxt = HOLDOFF;
          end
        end
      end
      HOLDOFF: begin
        cnt_nxt = cnt - 1'b1;
        if (cnt <= CNT_W'(1)) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= 2'd3;
      msi_req    <= 1'b0;
      msi_vec    <= 2'd0;
      svc_mask   <= 4'd0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      last_grant <= last_grant_nxt;
      msi_req    <= req_nxt;
      msi_vec    <= vec_nxt;
      svc_mask   <= mask_nxt;
      busy       <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_chi_intr_scheduler.sv
// Bench for chi_intr_scheduler: vector table, directed corner sequences and
// randomized traffic against a cycle-level behavioural model.
module tb_chi_intr_scheduler;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic [3:0]       src_pend = 4'd0;
  logic [3:0]       src_en = 4'd0;
  logic [CNT_W-1:0] holdoff_cycles = '0;
  logic             msi_ack = 1'b0;
  logic             msi_req;
  logic [1:0]       msi_vec;
  logic [3:0]       svc_mask;
  logic             busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  chi_intr_scheduler #(.CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn), .src_pend(src_pend), .src_en(src_en),
    .holdoff_cycles(holdoff_cycles), .msi_req(msi_req), .msi_vec(msi_vec),
    .msi_ack(msi_ack), .svc_mask(svc_mask), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one outstanding message, a holdoff countdown, a served set.
  bit         m_on = 0;
  bit         m_req = 0;
  int         m_vec = 0;
  int         m_last = 3;
  int         m_hold = 0;
  logic [3:0] m_mask = 4'd0;

  task automatic model_step();
    logic [3:0] nm, elig;
    if (!resetn) begin
      m_on = 1; m_req = 0; m_vec = 0; m_last = 3; m_hold = 0; m_mask = 4'd0;
    end else if (m_on) begin
      nm = m_mask & src_pend;
      if (m_req) begin
        if (msi_ack) begin
          nm[m_vec] = 1'b1;
          m_last = m_vec;
          m_req  = 0;
          m_hold = int'(holdoff_cycles);
        end
      end else if (m_hold > 0) begin
        m_hold--;
      end else begin
        elig = src_pend & src_en & ~m_mask;
        for (int k = 1; k <= 4; k++) begin
          if (!m_req && elig[(m_last + k) % 4]) begin
            m_req = 1;
            m_vec = (m_last + k) % 4;
          end
        end
      end
      m_mask = nm;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    logic [7:0] exp_v;
    @(negedge clk);
    if (m_on) begin
      exp_v = {m_req, 2'(m_vec), m_mask, (m_req || m_hold > 0)};
      chk("model", {24'd0, msi_req, msi_vec, svc_mask, busy}, {24'd0, exp_v});
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    resetn = 1'b0; msi_ack = 1'b0;
    step();
    resetn = 1'b1;
  endtask

  task automatic pulse_ack();
    msi_ack = 1'b1;
    step();
    msi_ack = 1'b0;
  endtask

  task automatic wait_req(input string name, output int vec, output int n);
    n = 0;
    while (!msi_req && n < 50) begin
      step();
      n++;
    end
    if (!msi_req) begin
      checks++;
      errors++;
      $display("FAIL %s: no msi_req within %0d cycles", name, n);
      vec = -1;
    end else begin
      vec = int'(msi_vec);
    end
  endtask

  typedef struct {
    logic       rstn;
    logic [3:0] pend;
    logic [3:0] en;
    logic       ack;
    logic [3:0] hold;
    logic       req;
    logic [1:0] vec;
    logic [3:0] mask;
    logic       bsy;
  } row_t;

  row_t tbl [14];

  initial begin
    int v, n, seen;
    //            rstn  pend   en     ack   hold   req   vec    mask   busy
    tbl[0]  = '{1'b0, 4'h0, 4'hF, 1'b0, 4'd0, 1'b0, 2'd0, 4'h0, 1'b0};
    tbl[1]  = '{1'b1, 4'h1, 4'hF, 1'b0, 4'd0, 1'b1, 2'd0, 4'h0, 1'b1};
    tbl[2]  = '{1'b1, 4'h1, 4'hF, 1'b0, 4'd0, 1'b1, 2'd0, 4'h0, 1'b1};
    tbl[3]  = '{1'b1, 4'h1, 4'hF, 1'b0, 4'd0, 1'b1, 2'd0, 4'h0, 1'b1};
    tbl[4]  = '{1'b1, 4'h1, 4'hF, 1'b1, 4'd0, 1'b0, 2'd0, 4'h1, 1'b0};
    tbl[5]  = '{1'b1, 4'h1, 4'hF, 1'b0, 4'd0, 1'b0, 2'd0, 4'h1, 1'b0};
    tbl[6]  = '{1'b1, 4'h0, 4'hF, 1'b0, 4'd0, 1'b0, 2'd0, 4'h0, 1'b0};
    tbl[7]  = '{1'b1, 4'h4, 4'hF, 1'b0, 4'd0, 1'b1, 2'd2, 4'h0, 1'b1};
    tbl[8]  = '{1'b1, 4'h4, 4'hF, 1'b1, 4'd2, 1'b0, 2'd2, 4'h4, 1'b1};
    tbl[9]  = '{1'b1, 4'h4, 4'hF, 1'b0, 4'd2, 1'b0, 2'd2, 4'h4, 1'b1};
    tbl[10] = '{1'b1, 4'h4, 4'hF, 1'b1, 4'd2, 1'b0, 2'd2, 4'h4, 1'b0};
    tbl[11] = '{1'b1, 4'h5, 4'hF, 1'b0, 4'd0, 1'b1, 2'd0, 4'h4, 1'b1};
    tbl[12] = '{1'b1, 4'h1, 4'hF, 1'b1, 4'd0, 1'b0, 2'd0, 4'h1, 1'b0};
    tbl[13] = '{1'b1, 4'h0, 4'hF, 1'b1, 4'd0, 1'b0, 2'd0, 4'h0, 1'b0};

    for (int i = 0; i < 14; i++) begin
      resetn = tbl[i].rstn;
      src_pend = tbl[i].pend;
      src_en = tbl[i].en;
      msi_ack = tbl[i].ack;
      holdoff_cycles = CNT_W'(tbl[i].hold);
      step();
      chk($sformatf("table_row%0d", i), {24'd0, msi_req, msi_vec, svc_mask, busy},
          {24'd0, tbl[i].req, tbl[i].vec, tbl[i].mask, tbl[i].bsy});
    end
    msi_ack = 1'b0;

    // Round-robin order with every source held pending.
    src_pend = 4'h0; src_en = 4'hF; holdoff_cycles = '0;
    do_reset();
    src_pend = 4'hF;
    for (int i = 0; i < 4; i++) begin
      wait_req("rr_wait", v, n);
      chk($sformatf("rr_order%0d", i), 32'(v), 32'(i));
      pulse_ack();
      if (v >= 0) src_pend[v] = 1'b0;
    end

    // Holdoff gap between consecutive messages.
    src_pend = 4'h0; holdoff_cycles = CNT_W'(5);
    do_reset();
    src_pend = 4'h3;
    wait_req("hold_wait1", v, n);
    chk("hold_first_vec", 32'(v), 32'd0);
    pulse_ack();
    wait_req("hold_wait2", v, n);
    chk("holdoff_gap", 32'(n), 32'd6);
    chk("hold_second_vec", 32'(v), 32'd1);
    pulse_ack();

    // A level-held source is not re-signalled until it drops.
    src_pend = 4'h0; holdoff_cycles = '0;
    do_reset();
    src_pend = 4'h4;
    wait_req("flood_wait1", v, n);
    chk("flood_vec", 32'(v), 32'd2);
    pulse_ack();
    seen = 0;
    repeat (8) begin
      step();
      if (msi_req) seen++;
    end
    chk("no_reflood", 32'(seen), 32'd0);
    src_pend = 4'h0;
    step();
    src_pend = 4'h4;
    wait_req("flood_wait2", v, n);
    chk("reflood_vec", 32'(v), 32'd2);
    pulse_ack();

    // Request survives src_en removal; set wins over same-cycle clear.
    src_pend = 4'h0;
    do_reset();
    src_pend = 4'h2;
    wait_req("en_wait", v, n);
    chk("en_vec", 32'(v), 32'd1);
    src_en = 4'hD;
    repeat (4) begin
      step();
      chk("en_hold", {30'd0, msi_req, msi_vec[0]}, 32'd3);
    end
    src_pend = 4'h0;
    pulse_ack();
    chk("set_wins_mask", {28'd0, svc_mask}, 32'h2);
    chk("set_wins_req", {31'd0, msi_req}, 32'd0);
    step();
    chk("late_clear", {28'd0, svc_mask}, 32'h0);
    src_en = 4'hF;

    // Reset in the middle of a request, then source 0 has priority.
    src_pend = 4'h0;
    do_reset();
    src_pend = 4'h8;
    wait_req("rst_wait1", v, n);
    chk("rst_first_vec", 32'(v), 32'd3);
    src_pend = 4'h9;
    resetn = 1'b0;
    step();
    chk("mid_reset", {29'd0, msi_req, |svc_mask, busy}, 32'd0);
    resetn = 1'b1;
    wait_req("rst_wait2", v, n);
    chk("post_reset_vec", 32'(v), 32'd0);
    pulse_ack();

    // Randomized traffic, checked cycle by cycle against the model.
    src_pend = 4'($urandom);
    src_en = 4'hF;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) src_pend[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 49) == 0) src_en = 4'($urandom);
      holdoff_cycles = CNT_W'($urandom_range(0, 3));
      if (msi_ack) msi_ack = 1'b0;
      else if (msi_req) msi_ack = ($urandom_range(0, 2) == 0);
      else msi_ack = ($urandom_range(0, 15) == 0);
      resetn = ($urandom_range(0, 399) != 0);
      step();
    end
    msi_ack = 1'b0;
    resetn = 1'b1;
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
